// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared types and defaults for the register-bank bus transfer
//               controller (FSM state encoding, move-command record).
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Default bus/register width and register index width.
  localparam int c_DATA_W = 8;
  localparam int c_SEL_W  = 3;

  // Command fields are stored at a fixed width large enough for 16
  // registers, so the FIFO type does not depend on the block's SEL_W.
  localparam int c_CMD_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    LOAD   = 2'd2
  } state_t;

  typedef struct packed {
    logic [c_CMD_SEL_W-1:0] src;
    logic [c_CMD_SEL_W-1:0] dst;
  } cmd_t;

  // True when both register indices address a register that exists.
  function automatic logic cmd_in_range(input cmd_t cmd, input int num_regs);
    return (int'(cmd.src) < num_regs) && (int'(cmd.dst) < num_regs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_transfer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_transfer_ctrl_if
// Description : Command handshake, register-bank data and bus outputs of the
//               bus transfer controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_transfer_ctrl_if
  import bus_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = c_DATA_W,
  parameter int SEL_W    = c_SEL_W
) ();

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [SEL_W-1:0]             cmd_src;
  logic [SEL_W-1:0]             cmd_dst;
  logic [NUM_REGS*DATA_W-1:0]   reg_data_in;
  logic [DATA_W-1:0]            bus_data;
  logic [NUM_REGS-1:0]          load_en;
  logic                         busy;
  logic                         xfer_done;
  logic                         cmd_err;

  // Command issuer and register bank side.
  modport master (
    output cmd_valid, cmd_src, cmd_dst, reg_data_in,
    input  cmd_ready, bus_data, load_en, busy, xfer_done, cmd_err
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, reg_data_in,
    output cmd_ready, bus_data, load_en, busy, xfer_done, cmd_err
  );

endinterface
`default_nettype wire

// File: rtl/bus_transfer_ctrl_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cmd_fifo
// Description : Synchronous FIFO of move commands. Pointers carry one extra
//               wrap bit to tell full from empty. No bypass: a pushed entry
//               is visible at head the cycle after the push.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  push,
  input  cmd_t din,
  input  wire  pop,
  output logic full,
  output logic empty,
  output cmd_t head
);

  localparam int c_PTR_W = $clog2(DEPTH);

  cmd_t               r_mem [DEPTH];
  logic [c_PTR_W:0]   r_wr_ptr;
  logic [c_PTR_W:0]   r_rd_ptr;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                 (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  assign head  = r_mem[r_rd_ptr[c_PTR_W-1:0]];

  // Advance read/write pointers; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_PTR_W + 1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_PTR_W + 1)'(1);
    end
  end

  // Storage array; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/bus_transfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bus_transfer_ctrl
// Description : Owner of the shared register-bank bus. Queues move commands,
//               then per command drives the source register onto bus_data
//               (SELECT) and pulses the destination load enable (LOAD).
// Revision    : 1.0 - initial release
// ============================================================================
module bus_transfer_ctrl
  import bus_pkg::*;
#(
  parameter int NUM_REGS   = 8,
  parameter int DATA_W     = c_DATA_W,
  parameter int SEL_W      = c_SEL_W,
  parameter int FIFO_DEPTH = 4
) (
  input wire                  clk,
  input wire                  reset,
  bus_transfer_ctrl_if.slave  bus
);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [c_CMD_SEL_W-1:0] r_src;
  logic [c_CMD_SEL_W-1:0] r_dst;
  logic [DATA_W-1:0]      r_bus_data;
  logic                   r_cmd_err;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_latch;
  logic                   w_capture;
  logic                   w_cmd_err;
  cmd_t                   w_push_cmd;
  cmd_t                   w_head;
  logic [DATA_W-1:0]      w_src_data;
  logic [NUM_REGS-1:0]    w_load_dec;
  logic [DATA_W-1:0]      w_reg_arr [NUM_REGS];

  // ---------------------------------------------------------------- command
  // No pass-through when full: a pop in the same cycle does not open ready.
  assign w_push         = bus.cmd_valid && !w_full;
  assign w_push_cmd.src = c_CMD_SEL_W'(bus.cmd_src);
  assign w_push_cmd.dst = c_CMD_SEL_W'(bus.cmd_dst);

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (w_push_cmd),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  // ---------------------------------------------------------------- source mux
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_unpack
    assign w_reg_arr[g] = bus.reg_data_in[g*DATA_W +: DATA_W];
  end

  // Select the latched source register's output.
  always_comb begin
    w_src_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_src == c_CMD_SEL_W'(i)) w_src_data = w_reg_arr[i];
    end
  end

  // Decode the latched destination index to a one-hot enable vector.
  always_comb begin
    w_load_dec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_dst == c_CMD_SEL_W'(i)) w_load_dec[i] = 1'b1;
    end
  end

  // ---------------------------------------------------------------- FSM
  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_latch      = 1'b0;
    w_capture    = 1'b0;
    w_cmd_err    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (cmd_in_range(w_head, NUM_REGS)) begin
            w_latch      = 1'b1;
            w_state_next = SELECT;
          end else begin
            w_cmd_err = 1'b1;
          end
        end
      end
      SELECT: begin
        w_capture    = 1'b1;
        w_state_next = LOAD;
      end
      LOAD: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath registers: command latch, bus capture, error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src      <= '0;
      r_dst      <= '0;
      r_bus_data <= '0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_cmd_err <= w_cmd_err;
      if (w_latch) begin
        r_src <= w_head.src;
        r_dst <= w_head.dst;
      end
      if (w_capture) r_bus_data <= w_src_data;
    end
  end

  // ---------------------------------------------------------------- outputs
  // Registers give load priority over their own reset, so reset must
  // suppress the enable combinationally, even in the middle of LOAD.
  assign bus.load_en   = ((r_state == LOAD) && !reset) ? w_load_dec : '0;
  assign bus.xfer_done = (r_state == LOAD) && !reset;
  assign bus.bus_data  = r_bus_data;
  assign bus.cmd_err   = r_cmd_err;
  assign bus.cmd_ready = !w_full;
  assign bus.busy      = (r_state != IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_bus_transfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_transfer_ctrl
// Description : Self-checking bench for bus_transfer_ctrl with a scoreboard
//               of expected (destination, data) transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_transfer_ctrl;
  import bus_pkg::*;

  localparam int NUM_REGS   = 6;
  localparam int DATA_W     = 8;
  localparam int SEL_W      = 3;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [SEL_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DATA_W-1:0] regs [NUM_REGS];

  exp_t sb [$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;
  int xfer_seen = 0;
  int xfer_exp = 0;
  int err_seen = 0;
  int err_exp = 0;

  always #5 clk = ~clk;

  bus_transfer_ctrl_if #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .SEL_W    (SEL_W)
  ) bif ();

  bus_transfer_ctrl #(
    .NUM_REGS   (NUM_REGS),
    .DATA_W     (DATA_W),
    .SEL_W      (SEL_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  // Register bank outputs as seen by the controller.
  always_comb begin
    bif.reg_data_in = '0;
    for (int i = 0; i < NUM_REGS; i++) bif.reg_data_in[i*DATA_W +: DATA_W] = regs[i];
  end

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every LOAD cycle must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bif.cmd_err === 1'b1) err_seen++;
    if (bif.xfer_done === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("xfer_unexpected", 32'(bif.xfer_done), 32'd0);
      end else begin
        e = sb.pop_front();
        xfer_seen++;
        check_eq("xfer_load_en", 32'(bif.load_en), 32'(1) << e.dst);
        check_eq("xfer_bus_data", 32'(bif.bus_data), 32'(e.data));
      end
    end else begin
      check_eq("load_en_idle", 32'(bif.load_en), 32'd0);
    end
  end

  // Offer one command, wait (bounded) for ready, record the expectation.
  task automatic push_cmd(input int src, input int dst);
    int waited = 0;
    bif.cmd_valid = 1'b1;
    bif.cmd_src   = SEL_W'(src);
    bif.cmd_dst   = SEL_W'(dst);
    while (bif.cmd_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (bif.cmd_ready !== 1'b1) begin
      check_eq("push_timeout", 32'(bif.cmd_ready), 32'd1);
      bif.cmd_valid = 1'b0;
      return;
    end
    if (src < NUM_REGS && dst < NUM_REGS) begin
      sb.push_back('{dst: SEL_W'(dst), data: regs[src]});
      xfer_exp++;
    end else begin
      err_exp++;
    end
    @(posedge clk); #1;
    last_acc = cyc;
    bif.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bif.busy !== 1'b0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("wait_idle", 32'(bif.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    bif.cmd_valid = 1'b0;
    bif.cmd_src   = '0;
    bif.cmd_dst   = '0;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("rst_bus_data",  32'(bif.bus_data),  32'd0);
    check_eq("rst_load_en",   32'(bif.load_en),   32'd0);
    check_eq("rst_xfer_done", 32'(bif.xfer_done), 32'd0);
    check_eq("rst_cmd_err",   32'(bif.cmd_err),   32'd0);
    check_eq("rst_busy",      32'(bif.busy),      32'd0);
    check_eq("rst_cmd_ready", 32'(bif.cmd_ready), 32'd1);

    // ---- single move 3 -> 5, cycle-exact latency
    regs[3] = 8'hA5;
    push_cmd(3, 5);                       // accepted at E0
    @(posedge clk); #1;                   // after E1: SELECT
    check_eq("sm_busy_e1",  32'(bif.busy),      32'd1);
    check_eq("sm_done_e1",  32'(bif.xfer_done), 32'd0);
    check_eq("sm_bus_e1",   32'(bif.bus_data),  32'd0);
    @(posedge clk); #1;                   // after E2: LOAD
    check_eq("sm_bus_e2",   32'(bif.bus_data),  32'hA5);
    check_eq("sm_load_e2",  32'(bif.load_en),   32'b100000);
    check_eq("sm_done_e2",  32'(bif.xfer_done), 32'd1);
    @(posedge clk); #1;                   // after E3: IDLE
    check_eq("sm_done_e3",  32'(bif.xfer_done), 32'd0);
    check_eq("sm_load_e3",  32'(bif.load_en),   32'd0);
    check_eq("sm_busy_e3",  32'(bif.busy),      32'd0);
    check_eq("sm_hold_e3",  32'(bif.bus_data),  32'hA5);

    // ---- self move 0 -> 0
    regs[0] = 8'h3C;
    push_cmd(0, 0);
    wait_idle();

    // ---- source changes right after the SELECT edge
    regs[1] = 8'h11;
    push_cmd(1, 4);
    @(posedge clk); #1;                   // SELECT
    @(posedge clk); #1;                   // SELECT edge passed, LOAD
    regs[1] = 8'h22;
    #1;
    check_eq("mid_bus_load", 32'(bif.bus_data), 32'h11);
    @(posedge clk); #1;
    check_eq("mid_bus_idle", 32'(bif.bus_data), 32'h11);
    wait_idle();

    // ---- out-of-range command, then a normal one
    push_cmd(7, 2);
    @(posedge clk); #1;                   // after pop edge
    check_eq("oor_err_pulse", 32'(bif.cmd_err),  32'd1);
    check_eq("oor_busy",      32'(bif.busy),     32'd0);
    check_eq("oor_bus_held",  32'(bif.bus_data), 32'h11);
    @(posedge clk); #1;
    check_eq("oor_err_low",   32'(bif.cmd_err),  32'd0);
    check_eq("oor_bus_held2", 32'(bif.bus_data), 32'h11);
    regs[2] = 8'h5A;
    push_cmd(2, 3);
    wait_idle();

    // ---- FIFO fill and drain
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'h60 + 8'(i);
    push_cmd(0, 5);
    a0 = last_acc;
    push_cmd(1, 4);
    push_cmd(2, 3);
    push_cmd(3, 2);
    push_cmd(4, 1);
    push_cmd(5, 0);
    check_eq("fifo_no_stall",   32'(last_acc - a0), 32'd5);
    check_eq("fifo_ready_full", 32'(bif.cmd_ready), 32'd0);
    @(posedge clk); #1;                   // pop pending at next edge
    check_eq("fifo_ready_pop_cycle", 32'(bif.cmd_ready), 32'd0);
    check_eq("fifo_busy",            32'(bif.busy),      32'd1);
    push_cmd(0, 1);
    check_eq("fifo_held_accept", 32'(last_acc - a0), 32'd8);
    wait_idle();

    // ---- reset asserted during LOAD
    regs[2] = 8'h77;
    push_cmd(2, 1);
    for (int n = 0; n < 6 && bif.xfer_done !== 1'b1; n++) begin
      @(posedge clk); #1;
    end
    check_eq("rl_reached_load", 32'(bif.xfer_done), 32'd1);
    reset = 1'b1;
    sb.delete();
    xfer_exp--;
    #1;
    check_eq("rl_load_en_gated", 32'(bif.load_en),   32'd0);
    check_eq("rl_done_gated",    32'(bif.xfer_done), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("rl_bus_cleared", 32'(bif.bus_data),  32'd0);
    check_eq("rl_busy",        32'(bif.busy),      32'd0);
    check_eq("rl_cmd_ready",   32'(bif.cmd_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("rl_no_done",     32'(bif.xfer_done), 32'd0);
    push_cmd(4, 2);
    wait_idle();

    // ---- totals
    repeat (2) @(posedge clk);
    #1;
    check_eq("total_xfers",  32'(xfer_seen), 32'(xfer_exp));
    check_eq("total_errs",   32'(err_seen),  32'(err_exp));
    check_eq("sb_drained",   32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
